// File: rtl/fir_mac_arbiter_if.sv
// Purpose: bundle of the band request/grant and shared-MAC control signals for fir_mac_arbiter.
// Latency: none; signal bundle only.
// Backpressure: level req held by the band until its done pulse; no other flow control.
interface fir_mac_arbiter_if #(
  parameter int NUM_BANDS = 5,
  parameter int BURST_LEN = 1021,
  parameter int IDX_W     = $clog2(NUM_BANDS),
  parameter int CNT_W     = $clog2(BURST_LEN)
) ();

  logic [NUM_BANDS-1:0] req;
  logic [NUM_BANDS-1:0] gnt;
  logic [IDX_W-1:0]     idx;
  logic                 mac_clr;
  logic                 mac_en;
  logic [CNT_W-1:0]     tap_cnt;
  logic [NUM_BANDS-1:0] done;
  logic                 busy;

  // Arbiter side: consumes requests, drives grant and MAC sequencing.
  modport master (
    input  req,
    output gnt, idx, mac_clr, mac_en, tap_cnt, done, busy
  );

  // Band/MAC side: raises requests, observes grant and MAC sequencing.
  modport slave (
    output req,
    input  gnt, idx, mac_clr, mac_en, tap_cnt, done, busy
  );

endinterface

// File: rtl/fir_mac_arbiter.sv
// Purpose: round-robin arbiter + burst sequencer sharing one FIR MAC among the band filters.
// Latency: CLR one cycle after req is seen in IDLE, then BURST_LEN MAC cycles, then a one-cycle done.
// Backpressure: bands hold level req; dropping req[idx] mid-burst aborts it, no preemption by others.
module fir_mac_arbiter #(
  parameter int NUM_BANDS = 5,
  parameter int BURST_LEN = 1021,
  parameter int IDX_W     = $clog2(NUM_BANDS),
  parameter int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  fir_mac_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0]     LAST_TAP  = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]     LAST_BAND = IDX_W'(NUM_BANDS - 1);
  localparam logic [NUM_BANDS-1:0] ONE_HOT0  = NUM_BANDS'(1);

  state_t           state;
  logic [IDX_W-1:0] ptr;        // highest-priority band for the next scan
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  // Band after b, wrapping to 0 after the last band.
  function automatic logic [IDX_W-1:0] next_band(input logic [IDX_W-1:0] b);
    return (b == LAST_BAND) ? '0 : b + IDX_W'(1);
  endfunction

  // Scan requests starting at the pointer, wrapping modulo NUM_BANDS; first hit wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_BANDS);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Burst FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      bus.idx     <= '0;
      bus.gnt     <= '0;
      bus.mac_clr <= 1'b0;
      bus.mac_en  <= 1'b0;
      bus.tap_cnt <= '0;
      bus.done    <= '0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            state       <= S_CLR;
            bus.idx     <= sel_idx;
            bus.gnt     <= ONE_HOT0 << sel_idx;
            bus.mac_clr <= 1'b1;
            bus.busy    <= 1'b1;
          end
        end
        S_CLR: begin
          state       <= S_RUN;
          bus.mac_clr <= 1'b0;
          bus.mac_en  <= 1'b1;
          bus.tap_cnt <= '0;
        end
        S_RUN: begin
          if (!bus.req[bus.idx]) begin
            // Band withdrew: drop the burst silently, it still loses priority.
            state       <= S_IDLE;
            ptr         <= next_band(bus.idx);
            bus.idx     <= '0;
            bus.gnt     <= '0;
            bus.mac_en  <= 1'b0;
            bus.tap_cnt <= '0;
            bus.busy    <= 1'b0;
          end else if (bus.tap_cnt == LAST_TAP) begin
            state       <= S_DONE;
            bus.gnt     <= '0;
            bus.mac_en  <= 1'b0;
            bus.tap_cnt <= '0;
            bus.done    <= ONE_HOT0 << bus.idx;
          end else begin
            bus.tap_cnt <= bus.tap_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Served band becomes lowest priority for the next scan.
          state    <= S_IDLE;
          ptr      <= next_band(bus.idx);
          bus.idx  <= '0;
          bus.done <= '0;
          bus.busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
